audio_level_meter: RTL and testbench
====================================

// Module: audio_level_meter
// PURPOSE
//  Producer side of the on-screen audio waveform overlay: reduces the stereo audio stream to one
//  8-bit level byte per video frame and presents it with a one-cycle strobe. Tracks per-frame
//  peak |L|,|R|, applies peak-hold with linear decay, flags clipping. Sits between the core audio
//  mixer and the overlay renderer, which shifts in one level byte per frame.
// PARAMETERS
//  SAMPLE_W     16       signed audio sample width (>= 9)
//  DECAY        2        held level decrement per frame (0 = no decay)
//  CLIP_THRESH  15'h7F00 |sample| >= this sets clip for the frame
//  VS_ACT_LOW   1        1: vsync active low, frame ends on falling edge; 0: rising edge
// PORTS
//  clk_sys      in   1         system clock; all logic in this domain
//  reset        in   1         synchronous, active-high
//  audio_l      in   SAMPLE_W  left sample, signed two's complement
//  audio_r      in   SAMPLE_W  right sample, signed
//  audio_valid  in   1         one-cycle qualifier for audio_l/audio_r
//  vsync        in   1         video vsync, asynchronous to clk_sys
//  level        out  8         held peak level; stable between strobes
//  level_stb    out  1         one-cycle pulse when level/clip update
//  clip         out  1         frame just reported contained a clipped sample
//  frame_cnt    out  8         reported frames, wraps 255->0
// BEHAVIOUR
//  Reset: level=0, level_stb=0, clip=0, frame_cnt=0, peak accumulators=0, sync chain=inactive
//   level of vsync, FSM=ACC. Reset mid-frame discards the partial frame; no strobe issued.
//  Sync: vsync -> 2-flop synchronizer -> edge detector; frame_end is a 1-cycle pulse in cycle T,
//   3 clk_sys after the active edge reaches the first flop. Opposite edge ignored.
//  Abs: |x| saturates: -2^(SAMPLE_W-1) -> 2^(SAMPLE_W-1)-1; result SAMPLE_W-1 bits unsigned.
//  ACC: on audio_valid, pk_l=max(pk_l,|audio_l|), pk_r=max(pk_r,|audio_r|); clip_acc |= either
//   abs >= CLIP_THRESH (threshold compared at top SAMPLE_W-1 bits, i.e. scaled for SAMPLE_W!=16).
//  FSM: ACC -frame_end-> CALC -> HOLD -> EMIT -> ACC (one cycle each, unconditional).
//   T (frame_end in ACC): snapshot pk_l,pk_r,clip_acc; clear accumulators. A sample valid in
//    cycle T is the first sample of the NEW frame (loads accumulator, not the snapshot).
//   T+1 CALC: raw = max(snap_l,snap_r)[SAMPLE_W-2 -: 8] (top 8 magnitude bits, truncating).
//   T+2 HOLD: dec = (held > DECAY) ? held-DECAY : 0; held = (raw >= dec) ? raw : dec.
//   T+3 EMIT: level=held, clip=snap_clip, frame_cnt+=1, level_stb=1 for exactly this cycle.
//  Samples keep accumulating in CALC/HOLD/EMIT (into the new frame).
//  frame_end while not in ACC is dropped (frames < 4 clk_sys are not reportable); counted in
//   neither frame_cnt nor strobe.
//  Frame with no audio_valid: raw=0, level decays by DECAY, strobe still issued.
//  level/clip change only in EMIT; between strobes they hold.
// STRUCTURE
//  Package audio_meter_pkg: FSM state enum {ACC,CALC,HOLD,EMIT}; function sat_abs(SAMPLE_W);
//   localparam LVL_W=8.
//  Sub-module vsync_edge_sync (2-flop sync + edge select by VS_ACT_LOW, frame_end pulse out);
//   accumulators, FSM, hold/decay inline in audio_level_meter.
// TESTING
//  1 Reset, one frame with L=+16384 once, R=0 -> at T+3 level_stb=1, level=8'h80, clip=0,
//    frame_cnt=1; level_stb low all other cycles.
//  2 L=-32768 in frame -> abs saturates 32767, level=8'hFF, clip=1; next frame L=+100 only ->
//    raw=0, level=8'hFD (DECAY=2), clip=0.
//  3 Peak-hold: frames raw 0x40,0x10,0x3F -> level 0x40,0x3E,0x3F; silent frames from 0x03
//    -> 0x01 then 0x00, stays 0x00 (no underflow).
//  4 audio_valid L=0x7000 coincident with frame_end cycle -> excluded from reported frame,
//    appears (level 0xE0) in the following frame's report.
//  5 Two vsync active edges 2 clk_sys apart -> second dropped: one strobe, frame_cnt+1 only;
//    vsync glitch on opposite edge produces no frame_end.
//  6 reset asserted at CALC after a 0xFF frame -> no strobe, level=0, frame_cnt=0; 256 frames
//    -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/audio_meter_pkg.sv
// Shared types and helpers for the audio level meter: FSM states, level width
// and a saturating absolute-value function usable for any sample width up to 31 bits.
package audio_meter_pkg;

   localparam int LVL_W = 8;

   typedef enum logic [1:0] {
      ACC  = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2,
      EMIT = 2'd3
   } meter_state_e;

   // x is a w-bit sample sign-extended to 32 bits; the most negative code maps to the largest positive one.
   function automatic logic [31:0] sat_abs(input logic [31:0] x, input int w);
      logic [31:0] most_neg;
      most_neg = 32'hFFFF_FFFF << (w - 1);
      if (x == most_neg) begin
         sat_abs = ~most_neg;
      end else if (x[31]) begin
         sat_abs = ~x + 32'd1;
      end else begin
         sat_abs = x;
      end
   endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// Brings the asynchronous vsync into clk_sys and emits a registered one-cycle
// frame_end pulse on the active edge only.
module vsync_edge_sync #(
   parameter bit VS_ACT_LOW = 1'b1
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic vsync,
   output logic frame_end
);

   localparam logic IDLE_LVL = VS_ACT_LOW;

   logic sync1_q, sync2_q, prev_q, fe_q;
   logic fe_d;

   // Active edge is a transition away from the idle level.
   always_comb begin
      fe_d = 1'b0;
      if (VS_ACT_LOW) begin
         fe_d = prev_q & ~sync2_q;
      end else begin
         fe_d = ~prev_q & sync2_q;
      end
   end

   // Two-flop synchronizer, edge-history flop and pulse register.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sync1_q <= IDLE_LVL;
         sync2_q <= IDLE_LVL;
         prev_q  <= IDLE_LVL;
         fe_q    <= 1'b0;
      end else begin
         sync1_q <= vsync;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         fe_q    <= fe_d;
      end
   end

   assign frame_end = fe_q;

endmodule

// File: rtl/audio_level_meter.sv
// Reduces the stereo audio stream to one peak-held, decaying 8-bit level per
// video frame, with clip flag, frame counter and a one-cycle update strobe.
module audio_level_meter
   import audio_meter_pkg::*;
#(
   parameter int         SAMPLE_W    = 16,
   parameter int         DECAY       = 2,
   parameter logic [14:0] CLIP_THRESH = 15'h7F00,
   parameter bit         VS_ACT_LOW  = 1'b1
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] audio_l,
   input  logic [SAMPLE_W-1:0] audio_r,
   input  logic                audio_valid,
   input  logic                vsync,
   output logic [LVL_W-1:0]    level,
   output logic                level_stb,
   output logic                clip,
   output logic [LVL_W-1:0]    frame_cnt
);

   localparam int AW = SAMPLE_W - 1;
   localparam int THR_UP = (SAMPLE_W >= 16) ? (SAMPLE_W - 16) : 0;
   localparam int THR_DN = (SAMPLE_W < 16) ? (16 - SAMPLE_W) : 0;
   // Threshold is specified for 16-bit samples; rescale to the magnitude width.
   localparam logic [31:0] THR32 = ({17'd0, CLIP_THRESH} << THR_UP) >> THR_DN;
   localparam logic [LVL_W-1:0] DECAY_L = LVL_W'(DECAY);

   logic                frame_end_s;
   logic [31:0]         ext_l_s, ext_r_s;
   logic [AW-1:0]       abs_l_s, abs_r_s, max_snap_s;
   logic                clip_smp_s, take_s;
   logic [LVL_W-1:0]    dec_s, held_s;

   meter_state_e        state_q, state_d;
   logic [AW-1:0]       pk_l_q, pk_l_d, pk_r_q, pk_r_d;
   logic [AW-1:0]       snap_l_q, snap_l_d, snap_r_q, snap_r_d;
   logic                clip_acc_q, clip_acc_d, snap_clip_q, snap_clip_d;
   logic [LVL_W-1:0]    raw_q, raw_d;
   logic [LVL_W-1:0]    level_q, level_d, cnt_q, cnt_d;
   logic                clip_q, clip_d, stb_q, stb_d;

   vsync_edge_sync #(.VS_ACT_LOW(VS_ACT_LOW)) u_vsync (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .vsync     (vsync),
      .frame_end (frame_end_s)
   );

   assign ext_l_s    = {{(32-SAMPLE_W){audio_l[SAMPLE_W-1]}}, audio_l};
   assign ext_r_s    = {{(32-SAMPLE_W){audio_r[SAMPLE_W-1]}}, audio_r};
   assign abs_l_s    = AW'(sat_abs(ext_l_s, SAMPLE_W));
   assign abs_r_s    = AW'(sat_abs(ext_r_s, SAMPLE_W));
   assign clip_smp_s = (32'(abs_l_s) >= THR32) | (32'(abs_r_s) >= THR32);
   assign take_s     = frame_end_s & (state_q == ACC);
   assign max_snap_s = (snap_l_q >= snap_r_q) ? snap_l_q : snap_r_q;
   assign dec_s      = (level_q > DECAY_L) ? (level_q - DECAY_L) : {LVL_W{1'b0}};
   assign held_s     = (raw_q >= dec_s) ? raw_q : dec_s;

   // Accumulate, snapshot-and-clear at frame end, and run the report pipeline.
   always_comb begin
      state_d     = state_q;
      pk_l_d      = take_s ? {AW{1'b0}} : pk_l_q;
      pk_r_d      = take_s ? {AW{1'b0}} : pk_r_q;
      clip_acc_d  = take_s ? 1'b0 : clip_acc_q;
      snap_l_d    = snap_l_q;
      snap_r_d    = snap_r_q;
      snap_clip_d = snap_clip_q;
      raw_d       = raw_q;
      level_d     = level_q;
      clip_d      = clip_q;
      cnt_d       = cnt_q;
      stb_d       = 1'b0;

      // A sample in the frame-end cycle starts the new frame, after the clear above.
      if (audio_valid) begin
         pk_l_d     = (abs_l_s > pk_l_d) ? abs_l_s : pk_l_d;
         pk_r_d     = (abs_r_s > pk_r_d) ? abs_r_s : pk_r_d;
         clip_acc_d = clip_acc_d | clip_smp_s;
      end else begin
         clip_acc_d = clip_acc_d;
      end

      case (state_q)
         ACC: begin
            if (take_s) begin
               snap_l_d    = pk_l_q;
               snap_r_d    = pk_r_q;
               snap_clip_d = clip_acc_q;
               state_d     = CALC;
            end else begin
               state_d     = ACC;
            end
         end
         CALC: begin
            raw_d   = LVL_W'(max_snap_s >> (AW - LVL_W));
            state_d = HOLD;
         end
         HOLD: begin
            // Outputs are registered here so they are valid during the EMIT cycle.
            level_d = held_s;
            clip_d  = snap_clip_q;
            cnt_d   = cnt_q + 8'd1;
            stb_d   = 1'b1;
            state_d = EMIT;
         end
         EMIT: begin
            state_d = ACC;
         end
         default: begin
            state_d = ACC;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= ACC;
         pk_l_q      <= {AW{1'b0}};
         pk_r_q      <= {AW{1'b0}};
         clip_acc_q  <= 1'b0;
         snap_l_q    <= {AW{1'b0}};
         snap_r_q    <= {AW{1'b0}};
         snap_clip_q <= 1'b0;
         raw_q       <= {LVL_W{1'b0}};
         level_q     <= {LVL_W{1'b0}};
         clip_q      <= 1'b0;
         cnt_q       <= {LVL_W{1'b0}};
         stb_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pk_l_q      <= pk_l_d;
         pk_r_q      <= pk_r_d;
         clip_acc_q  <= clip_acc_d;
         snap_l_q    <= snap_l_d;
         snap_r_q    <= snap_r_d;
         snap_clip_q <= snap_clip_d;
         raw_q       <= raw_d;
         level_q     <= level_d;
         clip_q      <= clip_d;
         cnt_q       <= cnt_d;
         stb_q       <= stb_d;
      end
   end

   assign level     = level_q;
   assign clip      = clip_q;
   assign frame_cnt = cnt_q;
   assign level_stb = stb_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Scoreboard bench for audio_level_meter: each frame end pushes the modelled
// report, and every level_stb pops and compares level, clip and frame_cnt.
module tb_audio_level_meter;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [15:0] audio_l, audio_r;
   logic        audio_valid;
   logic        vsync;
   logic [7:0]  level;
   logic        level_stb;
   logic        clip;
   logic [7:0]  frame_cnt;

   typedef struct {
      logic [7:0] lvl;
      logic       clp;
      logic [7:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          m_pkl, m_pkr;
   logic        m_clip;
   logic [7:0]  m_level, m_cnt;

   audio_level_meter dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .audio_l     (audio_l),
      .audio_r     (audio_r),
      .audio_valid (audio_valid),
      .vsync       (vsync),
      .level       (level),
      .level_stb   (level_stb),
      .clip        (clip),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int m_abs(input int v);
      int a;
      a = (v < 0) ? -v : v;
      return (a > 32767) ? 32767 : a;
   endfunction

   task automatic model_clear();
      m_pkl  = 0;
      m_pkr  = 0;
      m_clip = 1'b0;
   endtask

   // Reference report for the frame that just closed.
   task automatic model_frame_end();
      int   raw, dec;
      exp_t e;
      raw = ((m_pkl > m_pkr) ? m_pkl : m_pkr) >> 7;
      dec = (m_level > 2) ? int'(m_level) - 2 : 0;
      m_level = 8'((raw >= dec) ? raw : dec);
      m_cnt   = m_cnt + 8'd1;
      e.lvl = m_level;
      e.clp = m_clip;
      e.cnt = m_cnt;
      sb_q.push_back(e);
      model_clear();
   endtask

   task automatic model_sample(input int l, input int r);
      if (m_abs(l) > m_pkl) m_pkl = m_abs(l);
      if (m_abs(r) > m_pkr) m_pkr = m_abs(r);
      if (m_abs(l) >= 32'h7F00 || m_abs(r) >= 32'h7F00) m_clip = 1'b1;
   endtask

   task automatic drive_sample(input int l, input int r);
      audio_l     = 16'(l);
      audio_r     = 16'(r);
      audio_valid = 1'b1;
      model_sample(l, r);
      @(negedge clk_sys);
      audio_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      audio_valid = 1'b0;
      vsync       = 1'b1;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      model_clear();
      m_level = 8'd0;
      m_cnt   = 8'd0;
      check_val("rst_level", level, 0);
      check_val("rst_stb", level_stb, 0);
      check_val("rst_clip", clip, 0);
      check_val("rst_cnt", frame_cnt, 0);
   endtask

   // Falling vsync; the 3rd negedge after it is the input slot of the frame-end cycle.
   task automatic end_frame(input bit samp_t, input int l);
      vsync = 1'b0;
      repeat (3) @(negedge clk_sys);
      model_frame_end();
      vsync = 1'b1;
      if (samp_t) begin
         drive_sample(l, 0);
      end else begin
         @(negedge clk_sys);
      end
      repeat (4) @(negedge clk_sys);
   endtask

   // Strobe monitor: every strobe must match the oldest outstanding report.
   always @(negedge clk_sys) begin
      if (level_stb) begin
         if (sb_q.size() == 0) begin
            check_val("stb_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("level", level, e.lvl);
            check_val("clip", clip, e.clp);
            check_val("frame_cnt", frame_cnt, e.cnt);
         end
      end
   end

   initial begin
      logic [15:0] t1, t2;
      audio_l = 16'd0;
      audio_r = 16'd0;
      m_level = 8'd0;
      m_cnt   = 8'd0;
      model_clear();
      @(negedge clk_sys);
      do_reset();

      // Basic frame, saturation/clip, then decay.
      drive_sample(16384, 0);
      end_frame(1'b0, 0);
      drive_sample(-32768, 0);
      end_frame(1'b0, 0);
      drive_sample(100, 0);
      end_frame(1'b0, 0);

      // Peak-hold sequence from zero.
      do_reset();
      drive_sample(32'h2000, 0);
      end_frame(1'b0, 0);
      drive_sample(0, 32'h0800);
      end_frame(1'b0, 0);
      drive_sample(32'h1F80, -5);
      end_frame(1'b0, 0);

      // Silent decay down to zero without underflow.
      do_reset();
      drive_sample(32'h0180, 0);
      end_frame(1'b0, 0);
      repeat (3) end_frame(1'b0, 0);

      // Clip threshold boundary.
      drive_sample(32'h7EFF, 0);
      end_frame(1'b0, 0);
      drive_sample(0, -32'h7F00);
      end_frame(1'b0, 0);

      // Sample in the frame-end cycle belongs to the following frame.
      drive_sample(32'h0100, 0);
      end_frame(1'b1, 32'h7000);
      end_frame(1'b0, 0);

      // Two active edges two cycles apart: second one is dropped.
      drive_sample(32'h1000, 32'h1800);
      vsync = 1'b0;
      @(negedge clk_sys);
      vsync = 1'b1;
      @(negedge clk_sys);
      vsync = 1'b0;
      @(negedge clk_sys);
      model_frame_end();
      vsync = 1'b1;
      repeat (8) @(negedge clk_sys);

      // Opposite edge alone: hold vsync low, then raise it; no report expected.
      end_frame(1'b0, 0);
      vsync = 1'b0;
      repeat (3) @(negedge clk_sys);
      model_frame_end();
      repeat (8) @(negedge clk_sys);
      vsync = 1'b1;
      repeat (10) @(negedge clk_sys);

      // Random frames with several samples on both channels.
      for (int f = 0; f < 6; f++) begin
         for (int s = 0; s < 3; s++) begin
            t1 = 16'($urandom);
            t2 = 16'($urandom);
            drive_sample(int'($signed(t1)), int'($signed(t2)));
         end
         end_frame(1'b0, 0);
      end

      // Reset during CALC of a full-scale frame discards that report.
      drive_sample(32'h4000, 0);
      end_frame(1'b0, 0);
      drive_sample(-32768, 0);
      vsync = 1'b0;
      repeat (3) @(negedge clk_sys);
      vsync = 1'b1;
      @(negedge clk_sys);
      reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      model_clear();
      m_level = 8'd0;
      m_cnt   = 8'd0;
      check_val("calc_rst_level", level, 0);
      check_val("calc_rst_cnt", frame_cnt, 0);
      check_val("calc_rst_clip", clip, 0);
      repeat (10) @(negedge clk_sys);

      // 256 frames wrap the frame counter back to zero.
      for (int f = 0; f < 256; f++) begin
         end_frame(1'b0, 0);
      end

      for (int w = 0; w < 40 && sb_q.size() != 0; w++) begin
         @(negedge clk_sys);
      end
      check_val("drain", sb_q.size(), 0);
      check_val("cnt_wrap", frame_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
